// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: widths, ALU control codes,
// the request record and a saturating counter helper.
package alu_pkg;

  localparam int DATA_W  = 32;
  localparam int CTRL_W  = 4;
  localparam int SHAMT_W = 5;
  localparam int TAG_W   = 4;

  localparam logic [CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_SLL = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_SRL = 4'b0100;
  localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SLT = 4'b0111;

  typedef struct packed {
    logic [DATA_W-1:0]  in1;
    logic [DATA_W-1:0]  in2;
    logic [CTRL_W-1:0]  ctrl;
    logic [SHAMT_W-1:0] shamt;
    logic [TAG_W-1:0]   tag;
  } alu_req_t;

  // Increment a 16-bit event counter, sticking at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/alu_rsp_slot.sv
// Single-entry response register for one requester. A load writes a new
// result; otherwise a consumed entry is released. The slot is "free" when it
// is empty or being drained this cycle, so a new result can land back-to-back.
module alu_rsp_slot #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_zero,
  input  logic [TAG_W-1:0]  load_tag,
  output logic              free,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic [TAG_W-1:0]  rsp_tag
);

  assign free = !rsp_valid || rsp_ready;

  // Load overrides drain; fields stay frozen while the entry waits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_tag   <= '0;
    end else if (load) begin
      rsp_valid <= 1'b1;
      rsp_data  <= load_data;
      rsp_zero  <= load_zero;
      rsp_tag   <= load_tag;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters
// (port 0: execute stage, port 1: address/aux unit), one op per cycle total.
// Optional statistics counters are built when ALU_ARB_STATS_EN is defined.
//
// Handshakes: a transfer happens on a channel in every cycle where valid and
// ready are both high at the rising clock edge. req_ready is a combinational
// grant and may depend on req_valid and rsp_ready. A response, once valid,
// holds all its fields stable until rsp_ready is seen high.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W  = alu_pkg::DATA_W,
  parameter int CTRL_W  = alu_pkg::CTRL_W,
  parameter int SHAMT_W = alu_pkg::SHAMT_W,
  parameter int TAG_W   = alu_pkg::TAG_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0][DATA_W-1:0]  req_in1,
  input  logic [1:0][DATA_W-1:0]  req_in2,
  input  logic [1:0][CTRL_W-1:0]  req_ctrl,
  input  logic [1:0][SHAMT_W-1:0] req_shamt,
  input  logic [1:0][TAG_W-1:0]   req_tag,
  output logic [1:0]              rsp_valid,
  input  logic [1:0]              rsp_ready,
  output logic [1:0][DATA_W-1:0]  rsp_data,
  output logic [1:0]              rsp_zero,
  output logic [1:0][TAG_W-1:0]   rsp_tag,
  output logic [DATA_W-1:0]       alu_in1,
  output logic [DATA_W-1:0]       alu_in2,
  output logic [CTRL_W-1:0]       alu_ctrl,
  output logic [SHAMT_W-1:0]      alu_shamt,
  input  logic [DATA_W-1:0]       alu_out,
  input  logic                    alu_zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]             stat_grant0,
  output logic [15:0]             stat_grant1,
  output logic [15:0]             stat_conflict
`endif
);

  logic [1:0] slot_free;
  logic [1:0] elig;
  logic [1:0] grant;
  logic       last_grant;  // port served most recently

  assign elig      = req_valid & slot_free;
  assign req_ready = grant;

  // Single eligible port wins; on a tie the port not served last wins.
  always_comb begin
    grant = elig;
    if (&elig) grant = last_grant ? 2'b01 : 2'b10;
  end

  // Route the winner onto the ALU; park at zero when idle to avoid toggling.
  always_comb begin
    alu_in1   = '0;
    alu_in2   = '0;
    alu_ctrl  = '0;
    alu_shamt = '0;
    if (grant[0]) begin
      alu_in1   = req_in1[0];
      alu_in2   = req_in2[0];
      alu_ctrl  = req_ctrl[0];
      alu_shamt = req_shamt[0];
    end else if (grant[1]) begin
      alu_in1   = req_in1[1];
      alu_in2   = req_in2[1];
      alu_ctrl  = req_ctrl[1];
      alu_shamt = req_shamt[1];
    end
  end

  // Remember who was served; reset value 1 gives port 0 the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        last_grant <= 1'b1;
    else if (|grant) last_grant <= grant[1];
  end

  for (genvar i = 0; i < 2; i++) begin : g_slot
    alu_rsp_slot #(
      .DATA_W(DATA_W),
      .TAG_W (TAG_W)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (grant[i]),
      .load_data(alu_out),
      .load_zero(alu_zero),
      .load_tag (req_tag[i]),
      .free     (slot_free[i]),
      .rsp_valid(rsp_valid[i]),
      .rsp_ready(rsp_ready[i]),
      .rsp_data (rsp_data[i]),
      .rsp_zero (rsp_zero[i]),
      .rsp_tag  (rsp_tag[i])
    );
  end

`ifdef ALU_ARB_STATS_EN
  // Per-port grant counts and tie-cycle count, all saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grant0   <= '0;
      stat_grant1   <= '0;
      stat_conflict <= '0;
    end else begin
      stat_grant0   <= sat_inc16(stat_grant0, grant[0]);
      stat_grant1   <= sat_inc16(stat_grant1, grant[1]);
      stat_conflict <= sat_inc16(stat_conflict, &elig);
    end
  end
`endif

endmodule
